// File: rtl/tick_bcd_timekeeper_pkg.sv
// Shared types, digit limits, FSM encoding and BCD range check for the timekeeper.
package tk_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t hh_t;
        bcd_t hh_o;
        bcd_t mm_t;
        bcd_t mm_o;
        bcd_t ss_t;
        bcd_t ss_o;
    } time_t;

    localparam bcd_t BCD_MAX_O        = 4'd9;
    localparam bcd_t BCD_MAX_T_MS     = 4'd5;
    localparam bcd_t BCD_MAX_HH_T     = 4'd2;
    localparam bcd_t BCD_MAX_HH_O_TOP = 4'd3;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_LOAD = 1'b1
    } tk_state_e;

    // True when t is a legal 24-hour time, 00:00:00 .. 23:59:59.
    function automatic logic bcd_time_valid(input time_t t);
        logic ok;
        ok = (t.ss_o <= BCD_MAX_O) && (t.ss_t <= BCD_MAX_T_MS) &&
             (t.mm_o <= BCD_MAX_O) && (t.mm_t <= BCD_MAX_T_MS) &&
             (t.hh_o <= BCD_MAX_O) && (t.hh_t <= BCD_MAX_HH_T);
        if (t.hh_t == BCD_MAX_HH_T && t.hh_o > BCD_MAX_HH_O_TOP) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/tick_bcd_timekeeper_if.sv
// Time-set valid/ready channel: the requester is master, the timekeeper is slave.
interface tick_bcd_timekeeper_if
    import tk_pkg::*;
();
    logic  set_valid;
    logic  set_ready;
    time_t set_time;

    modport master (output set_valid, output set_time, input set_ready);
    modport slave  (input set_valid, input set_time, output set_ready);
endinterface

// File: rtl/tick_bcd_timekeeper_sync.sv
// Synchronises the divided tick, detects its rising edge and prescales edges into second_tick.
module tick_edge_sync #(
    parameter int TICKS_PER_SEC = 1,
    parameter int SYNC_STAGES   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_in,
    input  logic clr,
    output logic second_tick
);
    localparam int PW = $clog2(TICKS_PER_SEC) + 1;
    localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   hist_reg;
    logic                   edge_reg;
    logic [PW-1:0]          cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg[0] <= 1'b0;
        end else begin
            sync_reg[0] <= tick_in;
        end
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_reg[gi] <= 1'b0;
                end else begin
                    sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_reg <= 1'b0;
            edge_reg <= 1'b0;
            cnt_reg  <= '0;
        end else begin
            hist_reg <= sync_reg[SYNC_STAGES-1];
            edge_reg <= sync_reg[SYNC_STAGES-1] & ~hist_reg;
            // A successful load restarts the second so it begins a full period later.
            if (clr) begin
                cnt_reg <= '0;
            end else if (edge_reg) begin
                cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + PW'(1);
            end
        end
    end

    assign second_tick = edge_reg && (cnt_reg == LAST);
endmodule

// File: rtl/tick_bcd_timekeeper.sv
// 24-hour BCD timekeeper driven by a divided tick, with a valid/ready time-set port.
// Optional alarm compare is built when ALARM_EN is defined.
module tick_bcd_timekeeper
    import tk_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tick_in,
    tick_bcd_timekeeper_if.slave        set,
    output logic                        set_err,
    output time_t                       time_bcd,
    output logic                        sec_pulse,
`ifdef ALARM_EN
    input  logic [15:0]                 alarm_time,
    input  logic                        alarm_arm,
    output logic                        alarm_out,
`endif
    output logic                        day_pulse
);
    tk_state_e state_reg, state_next;
    time_t     time_reg, time_inc, cap_reg;
    logic      day_wrap;
    logic      second_tick;
    logic      load_ok;

    assign load_ok  = (state_reg == S_LOAD) && bcd_time_valid(cap_reg);
    assign time_bcd = time_reg;

    tick_edge_sync #(
        .TICKS_PER_SEC (TICKS_PER_SEC),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_sync (
        .clk         (clk),
        .rst         (rst),
        .tick_in     (tick_in),
        .clr         (load_ok),
        .second_tick (second_tick)
    );

    always_comb begin
        time_inc = time_reg;
        day_wrap = 1'b0;
        if (time_reg.ss_o != BCD_MAX_O) begin
            time_inc.ss_o = time_reg.ss_o + 4'd1;
        end else begin
            time_inc.ss_o = '0;
            if (time_reg.ss_t != BCD_MAX_T_MS) begin
                time_inc.ss_t = time_reg.ss_t + 4'd1;
            end else begin
                time_inc.ss_t = '0;
                if (time_reg.mm_o != BCD_MAX_O) begin
                    time_inc.mm_o = time_reg.mm_o + 4'd1;
                end else begin
                    time_inc.mm_o = '0;
                    if (time_reg.mm_t != BCD_MAX_T_MS) begin
                        time_inc.mm_t = time_reg.mm_t + 4'd1;
                    end else begin
                        time_inc.mm_t = '0;
                        if (time_reg.hh_t == BCD_MAX_HH_T && time_reg.hh_o == BCD_MAX_HH_O_TOP) begin
                            time_inc.hh_t = '0;
                            time_inc.hh_o = '0;
                            day_wrap      = 1'b1;
                        end else if (time_reg.hh_o == BCD_MAX_O) begin
                            time_inc.hh_o = '0;
                            time_inc.hh_t = time_reg.hh_t + 4'd1;
                        end else begin
                            time_inc.hh_o = time_reg.hh_o + 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        set.set_ready = 1'b0;
        case (state_reg)
            S_RUN: begin
                set.set_ready = 1'b1;
                if (set.set_valid) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: state_next = S_RUN;
            default: state_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // The load cycle takes priority: a coincident second_tick is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            time_reg  <= '0;
            cap_reg   <= '0;
            set_err   <= 1'b0;
            sec_pulse <= 1'b0;
            day_pulse <= 1'b0;
`ifdef ALARM_EN
            alarm_out <= 1'b0;
`endif
        end else begin
            set_err   <= 1'b0;
            sec_pulse <= 1'b0;
            day_pulse <= 1'b0;
`ifdef ALARM_EN
            alarm_out <= 1'b0;
`endif
            if (state_reg == S_RUN && set.set_valid) begin
                cap_reg <= set.set_time;
            end
            if (state_reg == S_LOAD) begin
                if (load_ok) begin
                    time_reg <= cap_reg;
                end else begin
                    set_err <= 1'b1;
                end
            end else if (second_tick) begin
                time_reg  <= time_inc;
                sec_pulse <= 1'b1;
                day_pulse <= day_wrap;
`ifdef ALARM_EN
                alarm_out <= alarm_arm && (time_inc == time_t'({alarm_time, 8'h00}));
`endif
            end
        end
    end
endmodule
